// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, combinational lookup and one registered update per cycle.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_pc_f,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jump,
  input  logic        upd_mispredict,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];
  logic [31:0]        stat_updates_r;
  logic [31:0]        stat_mispredicts_r;

  logic [IDX_W-1:0]   lk_idx_s;
  logic [TAG_W-1:0]   lk_tag_s;
  logic               lk_hit_s;
  logic [31:0]        lk_seq_pc_s;
  logic               pred_taken_s;
  logic [31:0]        pred_pc_s;

  logic [IDX_W-1:0]   upd_idx_s;
  logic [TAG_W-1:0]   upd_tag_s;
  logic               upd_hit_s;
  logic               upd_acc_s;
  logic               ctr_we_s;
  logic               tgt_we_s;
  logic               alloc_s;
  logic [1:0]         ctr_next_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      ctr_inc = 2'b11;
    end else begin
      ctr_inc = c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      ctr_dec = 2'b00;
    end else begin
      ctr_dec = c - 2'b01;
    end
  endfunction

  assign lk_idx_s    = pc_f[IDX_W+1:2];
  assign lk_tag_s    = pc_f[31:IDX_W+2];
  assign lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
  assign lk_seq_pc_s = pc_f + 32'd4;

  // Lookup: prediction reflects pre-update state; reset forces fall-through.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_pc_s    = lk_seq_pc_s;
    if (rst) begin
      pred_taken_s = 1'b0;
      pred_pc_s    = lk_seq_pc_s;
    end else if (lk_hit_s && ctr_r[lk_idx_s][1]) begin
      pred_taken_s = 1'b1;
      pred_pc_s    = target_r[lk_idx_s];
    end else begin
      pred_taken_s = 1'b0;
      pred_pc_s    = lk_seq_pc_s;
    end
  end

  assign pred_taken_f = pred_taken_s;
  assign pred_pc_f    = pred_pc_s;

  assign upd_idx_s = upd_pc[IDX_W+1:2];
  assign upd_tag_s = upd_pc[31:IDX_W+2];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
  assign upd_acc_s = upd_valid && !rst;

  // Update decode: counter training on a hit, allocation on a taken miss.
  always_comb begin
    ctr_we_s   = 1'b0;
    tgt_we_s   = 1'b0;
    alloc_s    = 1'b0;
    ctr_next_s = ctr_r[upd_idx_s];
    if (upd_acc_s && upd_hit_s) begin
      ctr_we_s = 1'b1;
      case ({upd_is_jump, upd_taken})
        2'b10, 2'b11: begin
          ctr_next_s = 2'b11;
          tgt_we_s   = 1'b1;
        end
        2'b01: begin
          ctr_next_s = ctr_inc(ctr_r[upd_idx_s]);
          tgt_we_s   = 1'b1;
        end
        2'b00: begin
          ctr_next_s = ctr_dec(ctr_r[upd_idx_s]);
          tgt_we_s   = 1'b0;
        end
        default: begin
          ctr_we_s   = 1'b0;
          ctr_next_s = ctr_r[upd_idx_s];
        end
      endcase
    end else if (upd_acc_s && upd_taken) begin
      alloc_s    = 1'b1;
      ctr_we_s   = 1'b1;
      tgt_we_s   = 1'b1;
      ctr_next_s = upd_is_jump ? 2'b11 : 2'b10;
    end else begin
      ctr_we_s   = 1'b0;
      tgt_we_s   = 1'b0;
      alloc_s    = 1'b0;
      ctr_next_s = ctr_r[upd_idx_s];
    end
  end

  // Valid bits: the only per-entry state that reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (alloc_s) begin
      valid_r[upd_idx_s] <= 1'b1;
    end
  end

  // Entry payload: tag/target/ctr are don't-care until valid, so no reset.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      tag_r[upd_idx_s] <= upd_tag_s;
    end
    if (tgt_we_s) begin
      target_r[upd_idx_s] <= upd_target;
    end
    if (ctr_we_s) begin
      ctr_r[upd_idx_s] <= ctr_next_s;
    end
  end

  // Statistics counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates_r     <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else if (upd_valid) begin
      stat_updates_r <= stat_updates_r + 32'd1;
      if (upd_mispredict) begin
        stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
      end
    end
  end

  assign stat_updates     = stat_updates_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookups/stats,
// a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_mispredict;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  typedef struct packed {
    logic        chk_stats;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic [31:0] exp_upd;
    logic [31:0] exp_mis;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_f             (pc_f),
    .pred_taken_f     (pred_taken_f),
    .pred_pc_f        (pred_pc_f),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_is_jump      (upd_is_jump),
    .upd_mispredict   (upd_mispredict),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (pred_taken_f !== e.exp_taken || pred_pc_f !== e.exp_pc) begin
        bad++;
        $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h",
                 n, pred_taken_f, pred_pc_f, e.exp_taken, e.exp_pc);
      end
      if (e.chk_stats) begin
        total++;
        if (stat_updates !== e.exp_upd || stat_mispredicts !== e.exp_mis) begin
          bad++;
          $display("FAIL %s stats: got upd=%h mis=%h, want upd=%h mis=%h",
                   n, stat_updates, stat_mispredicts, e.exp_upd, e.exp_mis);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic uj, input logic um);
    @(posedge clk);
    #1;
    rst            = r;
    pc_f           = pc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_is_jump    = uj;
    upd_mispredict = um;
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_pred(input string n, input logic t, input logic [31:0] p);
    exp_t e;
    e = '{chk_stats: 1'b0, exp_taken: t, exp_pc: p, exp_upd: 32'h0, exp_mis: 32'h0};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic expect_all(input string n, input logic t, input logic [31:0] p,
                            input logic [31:0] u, input logic [31:0] m);
    exp_t e;
    e = '{chk_stats: 1'b1, exp_taken: t, exp_pc: p, exp_upd: u, exp_mis: m};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b1; pc_f = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_is_jump = 1'b0; upd_mispredict = 1'b0;

    // Reset defaults
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_pred("in_reset", 1'b0, 32'h104);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_all("in_reset2", 1'b0, 32'h104, 32'd0, 32'd0);
    look(32'h100);
    expect_all("reset_defaults", 1'b0, 32'h104, 32'd0, 32'd0);

    // Allocate then train down
    drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
    expect_pred("alloc_same_cycle", 1'b0, 32'h104);
    drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_all("alloc_ctr10", 1'b1, 32'h80, 32'd1, 32'd1);
    drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_all("train_ctr01", 1'b0, 32'h104, 32'd2, 32'd1);
    look(32'h100);
    expect_all("train_ctr00", 1'b0, 32'h104, 32'd3, 32'd1);

    // Saturation
    drive(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
    expect_pred("sat_first_miss", 1'b0, 32'h204);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
      expect_pred("sat_taken", 1'b1, 32'h40);
    end
    drive(1'b0, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_pred("sat_ctr11", 1'b1, 32'h40);
    look(32'h200);
    expect_all("sat_ctr10", 1'b1, 32'h40, 32'd9, 32'd1);

    // Aliasing / replacement (every PC here maps to index 0)
    drive(1'b0, 32'h140, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    expect_pred("alias_miss_a", 1'b0, 32'h144);
    look(32'h100);
    expect_pred("realloc_100", 1'b1, 32'h80);
    look(32'h140);
    expect_pred("alias_miss_b", 1'b0, 32'h144);
    drive(1'b0, 32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b1);
    expect_pred("alias_pre_upd", 1'b0, 32'h144);
    look(32'h140);
    expect_pred("alias_new", 1'b1, 32'h300);
    look(32'h100);
    expect_all("alias_evicted", 1'b0, 32'h104, 32'd11, 32'd2);

    // Same-cycle conflict and jump
    drive(1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h1000, 1'b1, 1'b1);
    expect_pred("conflict_no_bypass", 1'b0, 32'h184);
    drive(1'b0, 32'h180, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_pred("jump_taken", 1'b1, 32'h1000);
    look(32'h180);
    expect_all("jump_nt_ctr10", 1'b1, 32'h1000, 32'd13, 32'd3);
    look(32'h183);
    expect_pred("low_bits_ignored", 1'b1, 32'h1000);
    look(32'hFFFF_FFFC);
    expect_pred("seq_pc_wrap", 1'b0, 32'h0000_0000);

    // Statistics wrap via backdoor
    look(32'h180);
    expect_pred("pre_force", 1'b1, 32'h1000);
    force dut.stat_updates_r = 32'hFFFF_FFFF;
    #1;
    release dut.stat_updates_r;
    drive(1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h1000, 1'b0, 1'b0);
    expect_all("forced_max", 1'b1, 32'h1000, 32'hFFFF_FFFF, 32'd3);
    look(32'h180);
    expect_all("stat_wrap", 1'b1, 32'h1000, 32'd0, 32'd3);

    // Reset mid-operation with an update pending
    drive(1'b1, 32'h180, 1'b1, 32'h104, 1'b1, 32'h500, 1'b1, 1'b1);
    expect_pred("mid_reset_lookup", 1'b0, 32'h184);
    look(32'h180);
    expect_all("post_reset_miss", 1'b0, 32'h184, 32'd0, 32'd0);
    look(32'h104);
    expect_all("reset_upd_dropped", 1'b0, 32'h108, 32'd0, 32'd0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
